// File: rtl/fifo_skew_ctrl_pkg.sv
// fifo_skew_ctrl_pkg: shared state encodings and default sizes for the row-FIFO read scheduler
package fifo_skew_ctrl_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
  localparam int NUM_ROW_DEF    = 8;
  localparam int FIFO_DEPTH_DEF = 8;
endpackage

// File: rtl/fifo_skew_ctrl_if.sv
// fifo_skew_ctrl_if: sequencer/FIFO-side signals of the skewed read scheduler
interface fifo_skew_ctrl_if #(
  parameter int NUM_ROW = 8,
  parameter int LEN_W   = 4
);
  logic               start_i;
  logic               abort_i;
  logic [LEN_W-1:0]   len_i;
  logic [NUM_ROW-1:0] empty_i;
  logic [NUM_ROW-1:0] rden_o;
  logic [NUM_ROW-1:0] valid_o;
  logic               busy_o;
  logic               done_o;
  logic               stall_o;
  modport master (
    output start_i, abort_i, len_i, empty_i,
    input  rden_o, valid_o, busy_o, done_o, stall_o
  );
  modport slave (
    input  start_i, abort_i, len_i, empty_i,
    output rden_o, valid_o, busy_o, done_o, stall_o
  );
endinterface

// File: rtl/fifo_skew_window.sv
// fifo_skew_window: read window of one row, open while row <= t < row + len
module fifo_skew_window #(
  parameter int ROW   = 0,
  parameter int CNT_W = 5,
  parameter int LEN_W = 4
) (
  input  logic             run_i,
  input  logic [CNT_W-1:0] t_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             win_o
);
  localparam logic [CNT_W:0] LO = (CNT_W+1)'(ROW);
  logic [CNT_W:0] t_x, hi;
  assign t_x   = {1'b0, t_i};
  assign hi    = LO + (CNT_W+1)'(len_i);
  assign win_o = run_i && (t_x >= LO) && (t_x < hi);
endmodule

// File: rtl/fifo_skew_ctrl.sv
// fifo_skew_ctrl: drains len entries per row FIFO with a one-cycle-per-row diagonal skew;
// defining FIFO_SKEW_STALL_CNT_EN adds the saturating stall_cnt_o counter.
module fifo_skew_ctrl
  import fifo_skew_ctrl_pkg::*;
#(
  parameter int NUM_ROW    = NUM_ROW_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int LEN_W      = 4,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic rst_n,
  fifo_skew_ctrl_if.slave bus
`ifdef FIFO_SKEW_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt_o
`endif
);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(FIFO_DEPTH);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   t_q, t_d;
  logic [LEN_W-1:0]   len_q, len_d, len_clamp;
  logic [NUM_ROW-1:0] win, valid_q;
  logic               run, stall, last, accept;
  assign run       = state_q == S_RUN;
  assign len_clamp = (bus.len_i > MAX_LEN) ? MAX_LEN : bus.len_i;
  assign accept    = (state_q == S_IDLE) && bus.start_i && !bus.abort_i;
  assign last      = t_q == CNT_W'(len_q) + CNT_W'(NUM_ROW - 2);
  for (genvar g = 0; g < NUM_ROW; g++) begin : g_win
    fifo_skew_window #(.ROW(g), .CNT_W(CNT_W), .LEN_W(LEN_W)) u_win (
      .run_i(run),
      .t_i  (t_q),
      .len_i(len_q),
      .win_o(win[g])
    );
  end
  // one empty row inside its window freezes every row so the skew survives
  assign stall       = |(win & bus.empty_i);
  assign bus.rden_o  = (stall || bus.abort_i) ? '0 : win;
  assign bus.stall_o = run && stall;
  assign bus.busy_o  = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.done_o  = (state_q == S_DONE) && !bus.abort_i;
  assign bus.valid_o = valid_q;
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    len_d   = len_q;
    if (bus.abort_i) begin
      state_d = S_IDLE;
      t_d     = '0;
    end else if (accept) begin
      state_d = (bus.len_i == '0) ? S_DONE : S_RUN;
      len_d   = len_clamp;
      t_d     = '0;
    end else if (run && !stall) begin
      state_d = last ? S_DONE : S_RUN;
      t_d     = last ? '0 : t_q + CNT_W'(1);
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      len_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      len_q   <= len_d;
      valid_q <= bus.rden_o;
    end
  end
`ifdef FIFO_SKEW_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else if (accept) stall_cnt_q <= '0;
    else if (bus.stall_o && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
  end
  assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_skew_ctrl.sv
// tb_fifo_skew_ctrl: directed cycle-by-cycle vectors against a 4-row occupancy model of the FIFO bank
module tb_fifo_skew_ctrl;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] push;
  logic flush;
  logic [N-1:0] uf;
  int cnt[N];
  int rd_cnt[N];
  int vectors = 0;
  int errs = 0;
  always #5 clk = ~clk;
  fifo_skew_ctrl_if #(.NUM_ROW(N), .LEN_W(4)) bus ();
`ifdef FIFO_SKEW_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  fifo_skew_ctrl #(.NUM_ROW(N), .FIFO_DEPTH(8), .LEN_W(4), .CNT_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef FIFO_SKEW_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt)
`endif
  );
  always @(posedge clk) begin
    for (int r = 0; r < N; r++) begin
      if (flush) begin
        cnt[r]    <= 0;
        rd_cnt[r] <= 0;
      end else begin
        cnt[r]    <= cnt[r] + int'(push[r]) - int'(bus.rden_o[r]);
        rd_cnt[r] <= rd_cnt[r] + int'(bus.rden_o[r]);
        if (bus.rden_o[r] && cnt[r] == 0) uf[r] <= 1'b1;
      end
    end
  end
  always_comb begin
    bus.empty_i = '0;
    for (int r = 0; r < N; r++) bus.empty_i[r] = (cnt[r] == 0);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic st, input logic ab, input logic [N-1:0] psh,
                     input logic [N-1:0] e_rden, input logic [N-1:0] e_valid,
                     input logic e_busy, input logic e_done, input logic e_stall);
    @(posedge clk);
    #1;
    bus.start_i = st;
    bus.abort_i = ab;
    push = psh;
    #1;
    chk({tag, " rden"}, 32'(bus.rden_o), 32'(e_rden));
    chk({tag, " valid"}, 32'(bus.valid_o), 32'(e_valid));
    chk({tag, " busy"}, 32'(bus.busy_o), 32'(e_busy));
    chk({tag, " done"}, 32'(bus.done_o), 32'(e_done));
    chk({tag, " stall"}, 32'(bus.stall_o), 32'(e_stall));
  endtask
  task automatic fifo_flush();
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    push = '0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask
  task automatic chk_reads(input string tag, input int exp);
    for (int r = 0; r < N; r++) chk($sformatf("%s reads row%0d", tag, r), 32'(rd_cnt[r]), 32'(exp));
  endtask
  initial begin
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.len_i = '0;
    push = '0;
    flush = 1'b0;
    uf = '0;
    #2;
    chk("rst rden", 32'(bus.rden_o), 0);
    chk("rst valid", 32'(bus.valid_o), 0);
    chk("rst busy", 32'(bus.busy_o), 0);
    chk("rst done", 32'(bus.done_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    fifo_flush();
    // plain drain, len 3
    bus.len_i = 4'd3;
    repeat (3) cyc("t1 fill", 0, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t1 c0", 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t1 c1", 0, 0, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0);
    cyc("t1 c2", 0, 0, 4'b0000, 4'b0011, 4'b0001, 1, 0, 0);
    cyc("t1 c3", 0, 0, 4'b0000, 4'b0111, 4'b0011, 1, 0, 0);
    cyc("t1 c4", 0, 0, 4'b0000, 4'b1110, 4'b0111, 1, 0, 0);
    cyc("t1 c5", 0, 0, 4'b0000, 4'b1100, 4'b1110, 1, 0, 0);
    cyc("t1 c6", 0, 0, 4'b0000, 4'b1000, 4'b1100, 1, 0, 0);
    cyc("t1 c7", 0, 0, 4'b0000, 4'b0000, 4'b1000, 1, 1, 0);
    cyc("t1 c8", 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    chk("t1 empty", 32'(bus.empty_i), 32'hF);
    chk_reads("t1", 3);
    // row 2 starved until four cycles after start
    fifo_flush();
    repeat (3) cyc("t2 fill", 0, 0, 4'b1011, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t2 c0", 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t2 c1", 0, 0, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0);
    cyc("t2 c2", 0, 0, 4'b0000, 4'b0011, 4'b0001, 1, 0, 0);
    cyc("t2 c3", 0, 0, 4'b0000, 4'b0000, 4'b0011, 1, 0, 1);
    cyc("t2 c4", 0, 0, 4'b0100, 4'b0000, 4'b0000, 1, 0, 1);
    cyc("t2 c5", 0, 0, 4'b0100, 4'b0111, 4'b0000, 1, 0, 0);
    cyc("t2 c6", 0, 0, 4'b0100, 4'b1110, 4'b0111, 1, 0, 0);
    cyc("t2 c7", 0, 0, 4'b0000, 4'b1100, 4'b1110, 1, 0, 0);
    cyc("t2 c8", 0, 0, 4'b0000, 4'b1000, 4'b1100, 1, 0, 0);
    cyc("t2 c9", 0, 0, 4'b0000, 4'b0000, 4'b1000, 1, 1, 0);
    cyc("t2 c10", 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    chk("t2 empty", 32'(bus.empty_i), 32'hF);
    chk_reads("t2", 3);
`ifdef FIFO_SKEW_STALL_CNT_EN
    chk("t6 stall_cnt", 32'(stall_cnt), 2);
`endif
    // zero-length drain
    fifo_flush();
    bus.len_i = 4'd0;
    cyc("t3 c0", 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t3 c1", 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0);
`ifdef FIFO_SKEW_STALL_CNT_EN
    chk("t6 stall_cnt clr", 32'(stall_cnt), 0);
`endif
    cyc("t3 c2", 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    chk_reads("t3", 0);
    // abort beats start, then abort mid-run, then a clean len 2 drain
    bus.len_i = 4'd3;
    cyc("t4 abst", 1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t4 idle", 0, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
    repeat (2) cyc("t4 fill", 0, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t4 c0", 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t4 c1", 0, 0, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0);
    cyc("t4 c2", 0, 0, 4'b0000, 4'b0011, 4'b0001, 1, 0, 0);
    cyc("t4 c3", 0, 1, 4'b0000, 4'b0000, 4'b0011, 1, 0, 0);
    cyc("t4 c4", 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t4 c5", 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    fifo_flush();
    bus.len_i = 4'd2;
    repeat (2) cyc("t4 fill2", 0, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t4 d0", 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t4 d1", 0, 0, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0);
    cyc("t4 d2", 0, 0, 4'b0000, 4'b0011, 4'b0001, 1, 0, 0);
    cyc("t4 d3", 0, 0, 4'b0000, 4'b0110, 4'b0011, 1, 0, 0);
    cyc("t4 d4", 0, 0, 4'b0000, 4'b1100, 4'b0110, 1, 0, 0);
    cyc("t4 d5", 0, 0, 4'b0000, 4'b1000, 4'b1100, 1, 0, 0);
    cyc("t4 d6", 0, 0, 4'b0000, 4'b0000, 4'b1000, 1, 1, 0);
    cyc("t4 d7", 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    chk_reads("t4", 2);
    // start during RUN is ignored
    fifo_flush();
    bus.len_i = 4'd3;
    repeat (3) cyc("t5 fill", 0, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t5 c0", 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t5 c1", 0, 0, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0);
    cyc("t5 c2", 1, 0, 4'b0000, 4'b0011, 4'b0001, 1, 0, 0);
    cyc("t5 c3", 1, 0, 4'b0000, 4'b0111, 4'b0011, 1, 0, 0);
    cyc("t5 c4", 0, 0, 4'b0000, 4'b1110, 4'b0111, 1, 0, 0);
    cyc("t5 c5", 0, 0, 4'b0000, 4'b1100, 4'b1110, 1, 0, 0);
    cyc("t5 c6", 0, 0, 4'b0000, 4'b1000, 4'b1100, 1, 0, 0);
    cyc("t5 c7", 0, 0, 4'b0000, 4'b0000, 4'b1000, 1, 1, 0);
    cyc("t5 c8", 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t5 c9", 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    chk_reads("t5", 3);
    // asynchronous reset in the middle of a drain
    fifo_flush();
    repeat (3) cyc("t5 fill2", 0, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t5 r0", 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t5 r1", 0, 0, 4'b0000, 4'b0001, 4'b0000, 1, 0, 0);
    cyc("t5 r2", 0, 0, 4'b0000, 4'b0011, 4'b0001, 1, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5 arst rden", 32'(bus.rden_o), 0);
    chk("t5 arst valid", 32'(bus.valid_o), 0);
    chk("t5 arst busy", 32'(bus.busy_o), 0);
    chk("t5 arst done", 32'(bus.done_o), 0);
    chk("t5 arst stall", 32'(bus.stall_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("t5 r3", 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("t5 r4", 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
    chk("t5 arst row0", 32'(rd_cnt[0]), 2);
    chk("t5 arst row1", 32'(rd_cnt[1]), 1);
    chk("underflow", 32'(uf), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
